// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-client memory arbiter:
// fetch port, data port and the shared external memory port.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_data;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_ready, mem_rdata,
        output if_ack, if_data, if_err,
        output d_ack, d_rdata, d_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_ready, mem_rdata,
        input  if_ack, if_data, if_err,
        input  d_ack, d_rdata, d_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client round-robin memory arbiter (fetch + data) with
// single-cycle acks and a watchdog for unanswered requests.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        gnt;
    logic        pick;
    logic        any_req;
    logic        expire;
    logic        err_flag;
    logic [15:0] cnt;

    // 1 selects the data port; ties go to the port not served last
    assign any_req = bus.if_req | bus.d_req;
    assign pick    = (bus.if_req & bus.d_req) ? ~last_grant : bus.d_req;
    assign expire  = (TIMEOUT != 0) && (cnt == LAST) && !bus.mem_ready;

    assign bus.if_err = bus.if_ack & err_flag;
    assign bus.d_err  = bus.d_ack & err_flag;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (bus.mem_ready || expire) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latch, memory port, watchdog and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant    <= 1'b1;
            gnt           <= 1'b0;
            cnt           <= '0;
            err_flag      <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_data   <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_rdata   <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt         <= pick;
                        last_grant  <= pick;
                        bus.mem_req <= 1'b1;
                        cnt         <= '0;
                        err_flag    <= 1'b0;
                        if (pick) begin
                            bus.mem_we    <= bus.d_we;
                            bus.mem_be    <= bus.d_be;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                        end else begin
                            bus.mem_we    <= 1'b0;
                            bus.mem_be    <= 4'hF;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        if (gnt) begin
                            bus.d_rdata <= bus.mem_we ? 32'h0 : bus.mem_rdata;
                            bus.d_ack   <= 1'b1;
                        end else begin
                            bus.if_data <= bus.mem_rdata;
                            bus.if_ack  <= 1'b1;
                        end
                    end else if (expire) begin
                        bus.mem_req <= 1'b0;
                        err_flag    <= 1'b1;
                        if (gnt) begin
                            bus.d_rdata <= 32'hDEAD_BEEF;
                            bus.d_ack   <= 1'b1;
                        end else begin
                            bus.if_data <= 32'hDEAD_BEEF;
                            bus.if_ack  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected
// memory-port and ack records; a monitor pops and compares them.
module tb_mem_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } ack_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
        int          start;
    } mreq_t;

    logic clk;
    logic reset;
    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks;
    int          failures;
    int          cyc;
    int          waits;
    bit          mem_enable;
    logic [31:0] rd_val;
    ack_t        ackq[$];
    mreq_t       memq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory model: answers after 'waits' wait states with rd_val ^ addr
    initial begin
        int busy_cyc;
        busy_cyc = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && mem_enable) begin
                if (busy_cyc == waits) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rd_val ^ bus.mem_addr;
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = '0;
                end
                busy_cyc++;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = '0;
                busy_cyc = 0;
            end
        end
    end

    // Monitor: pops expected records whenever the DUT presents an event
    initial begin
        ack_t  e;
        mreq_t m;
        logic  prev;
        int    mlen;
        int    want_len;
        prev = 1'b0;
        mlen = 0;
        want_len = -1;
        forever begin
            @(negedge clk);
            if (bus.if_ack) begin
                if (ackq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL if_ack_unexpected data=%h", bus.if_data);
                end else begin
                    e = ackq.pop_front();
                    chk("if_ack_port", 32'(0), 32'(e.port));
                    chk("if_data", bus.if_data, e.data);
                    chk("if_err", 32'(bus.if_err), 32'(e.err));
                    chk("if_ack_cycle", cyc, e.cyc);
                end
            end
            if (bus.d_ack) begin
                if (ackq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d_ack_unexpected data=%h", bus.d_rdata);
                end else begin
                    e = ackq.pop_front();
                    chk("d_ack_port", 32'(1), 32'(e.port));
                    chk("d_rdata", bus.d_rdata, e.data);
                    chk("d_err", 32'(bus.d_err), 32'(e.err));
                    chk("d_ack_cycle", cyc, e.cyc);
                end
            end
            if (bus.mem_req && !prev) begin
                if (memq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_req_unexpected addr=%h", bus.mem_addr);
                    want_len = -1;
                end else begin
                    m = memq.pop_front();
                    chk("mem_req_start", cyc, m.start);
                    chk("mem_we", 32'(bus.mem_we), 32'(m.we));
                    chk("mem_be", 32'(bus.mem_be), 32'(m.be));
                    chk("mem_addr", bus.mem_addr, m.addr);
                    if (m.port) chk("mem_wdata", bus.mem_wdata, m.wdata);
                    want_len = m.len;
                end
                mlen = 1;
            end else if (bus.mem_req) begin
                mlen++;
            end else if (prev && want_len >= 0) begin
                chk("mem_req_len", mlen, want_len);
            end
            prev = bus.mem_req;
        end
    end

    task automatic fetch_req(input logic [31:0] a);
        bit got;
        got = 1'b0;
        bus.if_addr = a;
        bus.if_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.if_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL if_ack_wait actual=none required=ack");
        end
        bus.if_req = 1'b0;
    endtask

    task automatic data_req(input logic we, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] wd);
        bit got;
        got = 1'b0;
        bus.d_we = we;
        bus.d_be = be;
        bus.d_addr = a;
        bus.d_wdata = wd;
        bus.d_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.d_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL d_ack_wait actual=none required=ack");
        end
        bus.d_req = 1'b0;
    endtask

    function automatic ack_t mk_ack(input logic p, input logic [31:0] d,
                                    input logic er, input int c);
        ack_t r;
        r.port = p;
        r.data = d;
        r.err = er;
        r.cyc = c;
        return r;
    endfunction

    function automatic mreq_t mk_mem(input logic p, input logic we,
                                     input logic [3:0] be,
                                     input logic [31:0] a,
                                     input logic [31:0] wd,
                                     input int len, input int st);
        mreq_t r;
        r.port = p;
        r.we = we;
        r.be = be;
        r.addr = a;
        r.wdata = wd;
        r.len = len;
        r.start = st;
        return r;
    endfunction

    initial begin
        int k;
        checks = 0;
        failures = 0;
        waits = 0;
        mem_enable = 1'b1;
        rd_val = '0;
        reset = 1'b0;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_be = '0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_mem_req", 32'(bus.mem_req), 32'(0));
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_if_ack", 32'(bus.if_ack), 32'(0));
        chk("rst_d_ack", 32'(bus.d_ack), 32'(0));
        chk("rst_if_data", bus.if_data, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_errs", 32'({bus.if_err, bus.d_err}), 32'(0));
        reset = 1'b1;
        @(negedge clk);

        // Fetch, zero-wait memory
        k = cyc;
        waits = 0;
        rd_val = 32'h1234_5778;
        memq.push_back(mk_mem(0, 0, 4'hF, 32'h100, 0, 1, k + 1));
        ackq.push_back(mk_ack(0, 32'h1234_5678, 0, k + 2));
        fetch_req(32'h100);
        @(negedge clk);

        // Data write, 3 wait states
        k = cyc;
        waits = 3;
        rd_val = 32'h5555_AAAA;
        memq.push_back(mk_mem(1, 1, 4'b0011, 32'h200, 32'hCAFE_F00D, 4, k + 1));
        ackq.push_back(mk_ack(1, 32'h0, 0, k + 5));
        data_req(1, 4'b0011, 32'h200, 32'hCAFE_F00D);
        chk("if_data_held", bus.if_data, 32'h1234_5678);
        @(negedge clk);

        // Data read, 1 wait state
        k = cyc;
        waits = 1;
        rd_val = 32'hA5A5_0000;
        memq.push_back(mk_mem(1, 0, 4'hF, 32'h300, 32'h0, 2, k + 1));
        ackq.push_back(mk_ack(1, 32'hA5A5_0300, 0, k + 3));
        data_req(0, 4'hF, 32'h300, 32'h0);
        @(negedge clk);

        // Both ports requesting continuously: F, D, F, D
        k = cyc;
        waits = 0;
        rd_val = 32'h0F0F_0000;
        memq.push_back(mk_mem(0, 0, 4'hF, 32'h400, 0, 1, k + 1));
        memq.push_back(mk_mem(1, 0, 4'hF, 32'h500, 0, 1, k + 4));
        memq.push_back(mk_mem(0, 0, 4'hF, 32'h404, 0, 1, k + 7));
        memq.push_back(mk_mem(1, 0, 4'hF, 32'h504, 0, 1, k + 10));
        ackq.push_back(mk_ack(0, 32'h0F0F_0400, 0, k + 2));
        ackq.push_back(mk_ack(1, 32'h0F0F_0500, 0, k + 5));
        ackq.push_back(mk_ack(0, 32'h0F0F_0404, 0, k + 8));
        ackq.push_back(mk_ack(1, 32'h0F0F_0504, 0, k + 11));
        fork
            begin
                fetch_req(32'h400);
                fetch_req(32'h404);
            end
            begin
                data_req(0, 4'hF, 32'h500, 32'h0);
                data_req(0, 4'hF, 32'h504, 32'h0);
            end
        join
        @(negedge clk);

        // Watchdog expiry on a fetch
        k = cyc;
        mem_enable = 1'b0;
        memq.push_back(mk_mem(0, 0, 4'hF, 32'h600, 0, 8, k + 1));
        ackq.push_back(mk_ack(0, 32'hDEAD_BEEF, 1, k + 9));
        fetch_req(32'h600);
        mem_enable = 1'b1;
        @(negedge clk);

        // Normal fetch after a timeout
        k = cyc;
        waits = 0;
        rd_val = 32'h7777_0000;
        memq.push_back(mk_mem(0, 0, 4'hF, 32'h700, 0, 1, k + 1));
        ackq.push_back(mk_ack(0, 32'h7777_0700, 0, k + 2));
        fetch_req(32'h700);
        @(negedge clk);

        // mem_ready in the very cycle the watchdog would expire
        k = cyc;
        waits = 7;
        rd_val = 32'h8888_0000;
        memq.push_back(mk_mem(1, 0, 4'hF, 32'h800, 0, 8, k + 1));
        ackq.push_back(mk_ack(1, 32'h8888_0800, 0, k + 9));
        data_req(0, 4'hF, 32'h800, 32'h0);
        @(negedge clk);

        // Reset in the middle of BUSY
        k = cyc;
        mem_enable = 1'b0;
        memq.push_back(mk_mem(0, 0, 4'hF, 32'h900, 0, -1, k + 1));
        bus.if_addr = 32'h900;
        bus.if_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_mem_req", 32'(bus.mem_req), 32'(1));
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_mem_req_drop", 32'(bus.mem_req), 32'(0));
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_clears_if_data", bus.if_data, 32'h0);
        reset = 1'b1;
        mem_enable = 1'b1;
        @(negedge clk);

        // Fetch after reset release completes in 2 cycles
        k = cyc;
        waits = 0;
        rd_val = 32'hAAAA_0000;
        memq.push_back(mk_mem(0, 0, 4'hF, 32'hA00, 0, 1, k + 1));
        ackq.push_back(mk_ack(0, 32'hAAAA_0A00, 0, k + 2));
        fetch_req(32'hA00);
        repeat (3) @(negedge clk);

        chk("ackq_drained", ackq.size(), 32'(0));
        chk("memq_drained", memq.size(), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
